// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and next-state select helper for the EX->MEM pipeline register.
package ex_mem_reg_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int ALUOP_W_DEF    = 8;
    localparam int CNT_W_DEF      = 2;

    localparam logic [DATA_W_DEF-1:0]     ZeroWord     = '0;
    localparam logic [REG_ADDR_W_DEF-1:0] NOPRegAddr   = '0;
    localparam logic                      WriteEnable  = 1'b1;
    localparam logic                      WriteDisable = 1'b0;
    localparam logic [ALUOP_W_DEF-1:0]    EXE_NOP_OP   = '0;

    typedef enum logic [1:0] {
        SEL_FLUSH   = 2'd0,
        SEL_HOLD    = 2'd1,
        SEL_BUBBLE  = 2'd2,
        SEL_ADVANCE = 2'd3
    } pipe_sel_t;

    // Edge priority: flush > stall_mem > stall_ex > advance (reset is handled asynchronously).
    function automatic pipe_sel_t pipe_sel(input logic flush, input logic stall_ex,
                                           input logic stall_mem);
        if (flush)
            return SEL_FLUSH;
        else if (stall_mem)
            return SEL_HOLD;
        else if (stall_ex)
            return SEL_BUBBLE;
        else
            return SEL_ADVANCE;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with flush, stall and multi-cycle HI/LO carry back to EX.
// Latency: one cycle EX->MEM, no combinational input->output path.
// Backpressure: stall_mem holds everything; stall_ex inserts a bubble and keeps the carry.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ALUOP_W    = ALUOP_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_ex,
    input  logic                  stall_mem,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic                  mem_valid,
    output logic                  mem_wreg,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic                  wreg;
        logic [REG_ADDR_W-1:0] wd;
        logic [DATA_W-1:0]     wdata;
        logic                  whilo;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     mem_addr;
        logic [DATA_W-1:0]     reg2;
    } slot_t;

    typedef struct packed {
        logic [2*DATA_W-1:0] hilo;
        logic [CNT_W-1:0]    cnt;
    } carry_t;

    localparam slot_t SLOT_NOP = '{
        valid:    WriteDisable,
        wreg:     WriteDisable,
        wd:       REG_ADDR_W'(NOPRegAddr),
        wdata:    DATA_W'(ZeroWord),
        whilo:    WriteDisable,
        hi:       DATA_W'(ZeroWord),
        lo:       DATA_W'(ZeroWord),
        aluop:    ALUOP_W'(EXE_NOP_OP),
        mem_addr: DATA_W'(ZeroWord),
        reg2:     DATA_W'(ZeroWord)
    };

    localparam carry_t CARRY_NOP = '{hilo: '0, cnt: '0};

    slot_t     slot_q, slot_d, slot_ex;
    carry_t    carry_q, carry_d;
    pipe_sel_t sel;

    always_comb begin
        slot_ex          = SLOT_NOP;
        slot_ex.valid    = WriteEnable;
        slot_ex.wreg     = ex_wreg;
        slot_ex.wd       = ex_wd;
        slot_ex.wdata    = ex_wdata;
        slot_ex.whilo    = ex_whilo;
        slot_ex.hi       = ex_hi;
        slot_ex.lo       = ex_lo;
        slot_ex.aluop    = ex_aluop;
        slot_ex.mem_addr = ex_mem_addr;
        slot_ex.reg2     = ex_reg2;
    end

    assign sel = pipe_sel(flush, stall_ex, stall_mem);

    // A bubble empties the MEM slot but latches EX's partial product so the
    // multi-cycle op can resume next cycle; an advance retires the carry.
    always_comb begin
        slot_d  = slot_q;
        carry_d = carry_q;
        unique case (sel)
            SEL_FLUSH: begin
                slot_d  = SLOT_NOP;
                carry_d = CARRY_NOP;
            end
            SEL_HOLD: begin
                slot_d  = slot_q;
                carry_d = carry_q;
            end
            SEL_BUBBLE: begin
                slot_d       = SLOT_NOP;
                carry_d.hilo = hilo_i;
                carry_d.cnt  = cnt_i;
            end
            SEL_ADVANCE: begin
                slot_d  = slot_ex;
                carry_d = CARRY_NOP;
            end
            default: begin
                slot_d  = SLOT_NOP;
                carry_d = CARRY_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= SLOT_NOP;
            carry_q <= CARRY_NOP;
        end else begin
            slot_q  <= slot_d;
            carry_q <= carry_d;
        end
    end

    assign mem_valid    = slot_q.valid;
    assign mem_wreg     = slot_q.wreg;
    assign mem_wd       = slot_q.wd;
    assign mem_wdata    = slot_q.wdata;
    assign mem_whilo    = slot_q.whilo;
    assign mem_hi       = slot_q.hi;
    assign mem_lo       = slot_q.lo;
    assign mem_aluop    = slot_q.aluop;
    assign mem_mem_addr = slot_q.mem_addr;
    assign mem_reg2     = slot_q.reg2;
    assign hilo_o       = carry_q.hilo;
    assign cnt_o        = carry_q.cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: vector table for single-cycle behaviour plus reset and 64-bit sequences.
module tb_ex_mem_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        flush, stall_ex, stall_mem;
    logic        ex_wreg, ex_whilo;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    // 64-bit instance
    logic         w_flush, w_stall_ex, w_stall_mem;
    logic         w_ex_wreg, w_ex_whilo;
    logic [4:0]   w_ex_wd;
    logic [63:0]  w_ex_wdata, w_ex_hi, w_ex_lo, w_ex_mem_addr, w_ex_reg2;
    logic [7:0]   w_ex_aluop;
    logic [127:0] w_hilo_i;
    logic [1:0]   w_cnt_i;
    logic         w_mem_valid, w_mem_wreg, w_mem_whilo;
    logic [4:0]   w_mem_wd;
    logic [63:0]  w_mem_wdata, w_mem_hi, w_mem_lo, w_mem_mem_addr, w_mem_reg2;
    logic [7:0]   w_mem_aluop;
    logic [127:0] w_hilo_o;
    logic [1:0]   w_cnt_o;

    ex_mem_reg #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush), .stall_ex(w_stall_ex), .stall_mem(w_stall_mem),
        .ex_wreg(w_ex_wreg), .ex_wd(w_ex_wd), .ex_wdata(w_ex_wdata), .ex_whilo(w_ex_whilo),
        .ex_hi(w_ex_hi), .ex_lo(w_ex_lo), .ex_aluop(w_ex_aluop), .ex_mem_addr(w_ex_mem_addr),
        .ex_reg2(w_ex_reg2), .hilo_i(w_hilo_i), .cnt_i(w_cnt_i),
        .mem_valid(w_mem_valid), .mem_wreg(w_mem_wreg), .mem_wd(w_mem_wd),
        .mem_wdata(w_mem_wdata), .mem_whilo(w_mem_whilo), .mem_hi(w_mem_hi), .mem_lo(w_mem_lo),
        .mem_aluop(w_mem_aluop), .mem_mem_addr(w_mem_mem_addr), .mem_reg2(w_mem_reg2),
        .hilo_o(w_hilo_o), .cnt_o(w_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Secondary EX fields are derived from wdata so every slot carries distinct values.
    function automatic logic [31:0] f_hi(input logic [31:0] d);   return ~d; endfunction
    function automatic logic [31:0] f_lo(input logic [31:0] d);   return d ^ 32'h5A5A_5A5A; endfunction
    function automatic logic [7:0]  f_op(input logic [31:0] d);   return d[7:0] ^ 8'h3C; endfunction
    function automatic logic [31:0] f_addr(input logic [31:0] d); return d + 32'h4; endfunction
    function automatic logic [31:0] f_reg2(input logic [31:0] d); return {d[15:0], d[31:16]}; endfunction

    typedef struct {
        logic        flush, s_ex, s_mem;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic        e_valid, e_wreg;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    initial begin
        // flush s_ex s_mem | wreg wd wdata hilo cnt | valid wreg wd wdata hilo cnt
        vec[0]  = '{0,0,0, 1, 5'd5,  32'hDEAD_BEEF, 64'h0,                   2'd0, 1,1,5'd5, 32'hDEAD_BEEF, 64'h0, 2'd0};
        vec[1]  = '{0,1,0, 1, 5'd7,  32'h1111_1111, 64'h0000_0001_FFFF_FFFE, 2'd1, 0,0,5'd0, 32'h0, 64'h0000_0001_FFFF_FFFE, 2'd1};
        vec[2]  = '{0,0,0, 1, 5'd9,  32'hCAFE_F00D, 64'h55,                  2'd2, 1,1,5'd9, 32'hCAFE_F00D, 64'h0, 2'd0};
        vec[3]  = '{0,0,0, 0, 5'd3,  32'h0000_1234, 64'h0,                   2'd0, 1,0,5'd3, 32'h0000_1234, 64'h0, 2'd0};
        vec[4]  = '{0,1,1, 1, 5'd31, 32'hFFFF_FFFF, 64'hAB,                  2'd3, 1,0,5'd3, 32'h0000_1234, 64'h0, 2'd0};
        vec[5]  = '{0,1,1, 1, 5'd30, 32'h8765_4321, 64'hCD,                  2'd1, 1,0,5'd3, 32'h0000_1234, 64'h0, 2'd0};
        vec[6]  = '{0,1,1, 1, 5'd29, 32'h0BAD_F00D, 64'hEF,                  2'd2, 1,0,5'd3, 32'h0000_1234, 64'h0, 2'd0};
        vec[7]  = '{0,0,1, 1, 5'd28, 32'h0000_00FF, 64'h12,                  2'd3, 1,0,5'd3, 32'h0000_1234, 64'h0, 2'd0};
        vec[8]  = '{0,1,0, 1, 5'd6,  32'hAAAA_5555, 64'h0000_00AA_0000_00BB, 2'd2, 0,0,5'd0, 32'h0, 64'h0000_00AA_0000_00BB, 2'd2};
        vec[9]  = '{0,1,1, 1, 5'd8,  32'h5555_AAAA, 64'h99,                  2'd1, 0,0,5'd0, 32'h0, 64'h0000_00AA_0000_00BB, 2'd2};
        vec[10] = '{0,0,0, 1, 5'd4,  32'h0000_00A5, 64'h0,                   2'd0, 1,1,5'd4, 32'h0000_00A5, 64'h0, 2'd0};
        vec[11] = '{1,1,1, 1, 5'd12, 32'hFEED_FACE, 64'h66,                  2'd3, 0,0,5'd0, 32'h0, 64'h0, 2'd0};
        vec[12] = '{0,1,0, 0, 5'd0,  32'h0,         64'h77,                  2'd1, 0,0,5'd0, 32'h0, 64'h77, 2'd1};
        vec[13] = '{1,0,0, 1, 5'd13, 32'h1313_1313, 64'h88,                  2'd2, 0,0,5'd0, 32'h0, 64'h0, 2'd0};
        vec[14] = '{0,0,0, 1, 5'd30, 32'h8000_0001, 64'h0,                   2'd0, 1,1,5'd30, 32'h8000_0001, 64'h0, 2'd0};
        vec[15] = '{1,1,0, 1, 5'd2,  32'h0000_0002, 64'h44,                  2'd1, 0,0,5'd0, 32'h0, 64'h0, 2'd0};

        // Reset with non-zero inputs everywhere
        rst = 1'b1;
        flush = 0; stall_ex = 0; stall_mem = 0;
        ex_wreg = 1; ex_wd = 5'd17; ex_wdata = 32'h0F0F_0F0F; ex_whilo = 1;
        ex_hi = 32'h1; ex_lo = 32'h2; ex_aluop = 8'h21; ex_mem_addr = 32'h100; ex_reg2 = 32'h3;
        hilo_i = 64'h1234; cnt_i = 2'd3;
        w_flush = 0; w_stall_ex = 0; w_stall_mem = 0;
        w_ex_wreg = 1; w_ex_wd = 5'd1; w_ex_wdata = 64'h1; w_ex_whilo = 1;
        w_ex_hi = 64'h1; w_ex_lo = 64'h1; w_ex_aluop = 8'h1; w_ex_mem_addr = 64'h1; w_ex_reg2 = 64'h1;
        w_hilo_i = 128'h1; w_cnt_i = 2'd1;
        step();
        step();
        chk("reset_valid", 128'(mem_valid), 128'h0);
        chk("reset_wd",    128'(mem_wd),    128'h0);
        chk("reset_wdata", 128'(mem_wdata), 128'h0);
        chk("reset_hilo",  128'(hilo_o),    128'h0);
        chk("reset_cnt",   128'(cnt_o),     128'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            flush     = vec[i].flush;
            stall_ex  = vec[i].s_ex;
            stall_mem = vec[i].s_mem;
            ex_wreg   = vec[i].wreg;
            ex_wd     = vec[i].wd;
            ex_wdata  = vec[i].wdata;
            ex_whilo  = vec[i].wdata[0];
            ex_hi     = f_hi(vec[i].wdata);
            ex_lo     = f_lo(vec[i].wdata);
            ex_aluop  = f_op(vec[i].wdata);
            ex_mem_addr = f_addr(vec[i].wdata);
            ex_reg2   = f_reg2(vec[i].wdata);
            hilo_i    = vec[i].hilo;
            cnt_i     = vec[i].cnt;
            step();
            chk($sformatf("v%0d_valid", i), 128'(mem_valid), 128'(vec[i].e_valid));
            chk($sformatf("v%0d_wreg", i),  128'(mem_wreg),  128'(vec[i].e_wreg));
            chk($sformatf("v%0d_wd", i),    128'(mem_wd),    128'(vec[i].e_wd));
            chk($sformatf("v%0d_wdata", i), 128'(mem_wdata), 128'(vec[i].e_wdata));
            chk($sformatf("v%0d_hilo", i),  128'(hilo_o),    128'(vec[i].e_hilo));
            chk($sformatf("v%0d_cnt", i),   128'(cnt_o),     128'(vec[i].e_cnt));
            chk($sformatf("v%0d_whilo", i), 128'(mem_whilo),
                vec[i].e_valid ? 128'(vec[i].e_wdata[0]) : 128'h0);
            chk($sformatf("v%0d_hi", i),    128'(mem_hi),
                vec[i].e_valid ? 128'(f_hi(vec[i].e_wdata)) : 128'h0);
            chk($sformatf("v%0d_lo", i),    128'(mem_lo),
                vec[i].e_valid ? 128'(f_lo(vec[i].e_wdata)) : 128'h0);
            chk($sformatf("v%0d_aluop", i), 128'(mem_aluop),
                vec[i].e_valid ? 128'(f_op(vec[i].e_wdata)) : 128'h0);
            chk($sformatf("v%0d_addr", i),  128'(mem_mem_addr),
                vec[i].e_valid ? 128'(f_addr(vec[i].e_wdata)) : 128'h0);
            chk($sformatf("v%0d_reg2", i),  128'(mem_reg2),
                vec[i].e_valid ? 128'(f_reg2(vec[i].e_wdata)) : 128'h0);
        end

        // Reset in the middle of a multi-cycle op drops the carry without waiting for an edge
        flush = 0; stall_mem = 0; stall_ex = 1;
        hilo_i = 64'hFACE_0000_0000_CAFE; cnt_i = 2'd1;
        step();
        chk("mc_hilo", 128'(hilo_o), 128'h0000_0000_0000_0000_FACE_0000_0000_CAFE);
        chk("mc_cnt",  128'(cnt_o),  128'd1);
        stall_ex = 0;
        step();
        chk("mc_adv_valid", 128'(mem_valid), 128'h1);
        chk("mc_adv_wdata", 128'(mem_wdata), 128'(ex_wdata));
        chk("mc_adv_cnt",   128'(cnt_o),     128'h0);
        stall_ex = 1;
        step();
        chk("mc2_cnt", 128'(cnt_o), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(mem_valid), 128'h0);
        chk("arst_wreg",  128'(mem_wreg),  128'h0);
        chk("arst_hilo",  128'(hilo_o),    128'h0);
        chk("arst_cnt",   128'(cnt_o),     128'h0);
        chk("arst_w_valid", 128'(w_mem_valid), 128'h0);
        #1;
        rst = 1'b0;
        chk("rel_valid", 128'(mem_valid), 128'h0);
        stall_ex = 0;

        // Wide build: every bit of the 64-bit fields survives
        w_ex_hi    = 64'hFFFF_FFFF_0000_0001;
        w_ex_wdata = 64'h8000_0000_0000_0003;
        w_ex_reg2  = 64'hA5A5_0000_0000_5A5A;
        step();
        chk("w64_valid", 128'(w_mem_valid), 128'h1);
        chk("w64_hi",    128'(w_mem_hi),    128'hFFFF_FFFF_0000_0001);
        chk("w64_wdata", 128'(w_mem_wdata), 128'h8000_0000_0000_0003);
        chk("w64_reg2",  128'(w_mem_reg2),  128'hA5A5_0000_0000_5A5A);
        w_stall_ex = 1;
        w_hilo_i = 128'h8000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE;
        w_cnt_i  = 2'd2;
        step();
        chk("w64_bub_valid", 128'(w_mem_valid), 128'h0);
        chk("w64_bub_hilo",  w_hilo_o, 128'h8000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
        chk("w64_bub_cnt",   128'(w_cnt_o), 128'd2);
        w_stall_ex = 0;
        step();
        chk("w64_adv_hilo", w_hilo_o, 128'h0);
        chk("w64_adv_hi",   128'(w_mem_hi), 128'hFFFF_FFFF_0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
